// File: rtl/aq_gemac_udp_tx_pkg.sv
// Shared constants and state encoding for the UDP/IPv4 datagram builder.
//   IP_VER_IHL   : version 4, 5-word header
//   IP_TOS       : type of service (unused, always 0)
//   IP_PROTO_UDP : IP protocol number for UDP
//   IP_FLAGS_DF  : flags/fragment word with Don't Fragment set
//   HDR_WORDS    : IP (5) + UDP (2) header words ahead of the payload
package aq_gemac_udp_tx_pkg;

  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_TOS       = 8'h00;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;
  localparam logic [15:0] HDR_WORDS    = 16'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CS0  = 3'd1,
    ST_CS1  = 3'd2,
    ST_CS2  = 3'd3,
    ST_WAIT = 3'd4,
    ST_HDR  = 3'd5,
    ST_PAY  = 3'd6
  } state_t;

endpackage

// File: rtl/aq_gemac_ip_csum.sv
// Three-stage pipelined ones-complement checksum of nine 16-bit terms.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : terms are valid this cycle
//   terms      : nine 16-bit header halfwords
//   done       : one-cycle pulse, csum valid (and held) from this cycle
//   csum       : inverted ones-complement sum
module aq_gemac_ip_csum (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0][15:0] terms,
  output logic             done,
  output logic [15:0]      csum
);

  logic [19:0] sum_next;
  logic [19:0] sum_reg;
  logic [16:0] fold_reg;
  logic        v1_reg;
  logic        v2_reg;

  // Nine 16-bit terms stay below 2^20, so 20 bits never overflow.
  always_comb begin
    sum_next = 20'd0;
    for (int i = 0; i < 9; i++) begin
      sum_next = sum_next + {4'b0, terms[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg  <= '0;
      fold_reg <= '0;
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
      done     <= 1'b0;
      csum     <= '0;
    end else begin
      v1_reg <= start;
      v2_reg <= v1_reg;
      done   <= v2_reg;
      if (start) begin
        sum_reg <= sum_next;
      end
      if (v1_reg) begin
        fold_reg <= {1'b0, sum_reg[15:0]} + {13'b0, sum_reg[19:16]};
      end
      // After the first fold a carry leaves the low half small, so the
      // second fold cannot carry again.
      if (v2_reg) begin
        csum <= ~(fold_reg[15:0] + {15'b0, fold_reg[16]});
      end
    end
  end

endmodule

// File: rtl/aq_gemac_udp_tx.sv
// UDP/IPv4 datagram builder feeding the IP core TX buffer.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   MY_IP_ADDRESS         : source IP, PEER_IP_ADDRESS: destination IP
//   APP_START/LENGTH/...  : request pulse with length and UDP ports
//   APP_BUSY, APP_LEN_ERR : request in progress, oversize request rejected
//   APP_DATA/VALID/READY  : payload word stream (byte0 in [31:24])
//   TX_BUFF_WE/START/END/DATA : datagram word output
//   TX_BUFF_READY/FULL/SPACE  : downstream buffer status
module aq_gemac_udp_tx
  import aq_gemac_udp_tx_pkg::*;
#(
  parameter logic [7:0] TTL         = 8'h40,
  parameter int         MAX_PAYLOAD = 1472
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] MY_IP_ADDRESS,
  input  logic [31:0] PEER_IP_ADDRESS,
  input  logic        APP_START,
  input  logic [15:0] APP_LENGTH,
  input  logic [15:0] APP_SRC_PORT,
  input  logic [15:0] APP_DST_PORT,
  output logic        APP_BUSY,
  output logic        APP_LEN_ERR,
  input  logic [31:0] APP_DATA,
  input  logic        APP_VALID,
  output logic        APP_READY,
  output logic        TX_BUFF_WE,
  output logic        TX_BUFF_START,
  output logic        TX_BUFF_END,
  output logic [31:0] TX_BUFF_DATA,
  input  logic        TX_BUFF_READY,
  input  logic        TX_BUFF_FULL,
  input  logic [9:0]  TX_BUFF_SPACE
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  state_t      state_reg;
  logic [15:0] len_reg, sport_reg, dport_reg, id_reg, pay_cnt_reg;
  logic [31:0] src_ip_reg, dst_ip_reg;
  logic [2:0]  hdr_idx_reg;
  logic [15:0] csum_reg;

  logic [15:0] totlen, udplen, pay_words, nwords;
  logic        space_ok, pay_last, csum_done;
  logic [15:0] csum_val;
  logic [31:0] hdr_word, pay_mask;
  logic [8:0][15:0] csum_terms;

  assign totlen    = len_reg + 16'd28;
  assign udplen    = len_reg + 16'd8;
  assign pay_words = (len_reg + 16'd3) >> 2;
  assign nwords    = HDR_WORDS + pay_words;
  assign space_ok  = TX_BUFF_READY && !TX_BUFF_FULL &&
                     ({6'b0, TX_BUFF_SPACE} >= nwords);
  assign pay_last  = (pay_cnt_reg == pay_words - 16'd1);
  assign APP_READY = (state_reg == ST_PAY) && !TX_BUFF_FULL;

  assign csum_terms = {{IP_VER_IHL, IP_TOS}, totlen, id_reg, IP_FLAGS_DF,
                       {TTL, IP_PROTO_UDP},
                       src_ip_reg[31:16], src_ip_reg[15:0],
                       dst_ip_reg[31:16], dst_ip_reg[15:0]};

  // Pipeline runs in lockstep with CS0..CS2; the result lands before W2.
  aq_gemac_ip_csum u_csum (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (state_reg == ST_CS0),
    .terms (csum_terms),
    .done  (csum_done),
    .csum  (csum_val)
  );

  always_comb begin
    case (hdr_idx_reg)
      3'd0:    hdr_word = {IP_VER_IHL, IP_TOS, totlen};
      3'd1:    hdr_word = {id_reg, IP_FLAGS_DF};
      3'd2:    hdr_word = {TTL, IP_PROTO_UDP, csum_reg};
      3'd3:    hdr_word = src_ip_reg;
      3'd4:    hdr_word = dst_ip_reg;
      3'd5:    hdr_word = {sport_reg, dport_reg};
      default: hdr_word = {udplen, 16'h0000};
    endcase
  end

  // Bytes past the payload length in the final word are forced to zero.
  always_comb begin
    pay_mask = 32'hFFFF_FFFF;
    if (pay_last) begin
      case (len_reg[1:0])
        2'd1:    pay_mask = 32'hFF00_0000;
        2'd2:    pay_mask = 32'hFFFF_0000;
        2'd3:    pay_mask = 32'hFFFF_FF00;
        default: pay_mask = 32'hFFFF_FFFF;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      sport_reg     <= '0;
      dport_reg     <= '0;
      src_ip_reg    <= '0;
      dst_ip_reg    <= '0;
      id_reg        <= '0;
      pay_cnt_reg   <= '0;
      hdr_idx_reg   <= '0;
      csum_reg      <= '0;
      APP_BUSY      <= 1'b0;
      APP_LEN_ERR   <= 1'b0;
      TX_BUFF_WE    <= 1'b0;
      TX_BUFF_START <= 1'b0;
      TX_BUFF_END   <= 1'b0;
      TX_BUFF_DATA  <= '0;
    end else begin
      TX_BUFF_WE    <= 1'b0;
      TX_BUFF_START <= 1'b0;
      TX_BUFF_END   <= 1'b0;
      APP_LEN_ERR   <= 1'b0;
      if (csum_done) begin
        csum_reg <= csum_val;
      end
      case (state_reg)
        ST_IDLE: begin
          // Busy is still high in the END cycle, so a start there is ignored.
          APP_BUSY <= 1'b0;
          if (APP_START && !APP_BUSY) begin
            if (APP_LENGTH > MAX_LEN) begin
              APP_LEN_ERR <= 1'b1;
            end else begin
              len_reg    <= APP_LENGTH;
              sport_reg  <= APP_SRC_PORT;
              dport_reg  <= APP_DST_PORT;
              src_ip_reg <= MY_IP_ADDRESS;
              dst_ip_reg <= PEER_IP_ADDRESS;
              APP_BUSY   <= 1'b1;
              state_reg  <= ST_CS0;
            end
          end
        end
        ST_CS0: state_reg <= ST_CS1;
        ST_CS1: state_reg <= ST_CS2;
        // W0 does not need the checksum, so it can leave while CS2 finishes.
        ST_CS2, ST_WAIT: begin
          if (space_ok) begin
            TX_BUFF_WE    <= 1'b1;
            TX_BUFF_START <= 1'b1;
            TX_BUFF_DATA  <= hdr_word;
            hdr_idx_reg   <= 3'd1;
            state_reg     <= ST_HDR;
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_HDR: begin
          TX_BUFF_WE   <= 1'b1;
          TX_BUFF_DATA <= hdr_word;
          if (hdr_idx_reg == 3'd6) begin
            hdr_idx_reg <= 3'd0;
            pay_cnt_reg <= '0;
            if (len_reg == 16'd0) begin
              TX_BUFF_END <= 1'b1;
              id_reg      <= id_reg + 16'd1;
              state_reg   <= ST_IDLE;
            end else begin
              state_reg <= ST_PAY;
            end
          end else begin
            hdr_idx_reg <= hdr_idx_reg + 3'd1;
          end
        end
        ST_PAY: begin
          if (APP_VALID && APP_READY) begin
            TX_BUFF_WE   <= 1'b1;
            TX_BUFF_DATA <= APP_DATA & pay_mask;
            pay_cnt_reg  <= pay_cnt_reg + 16'd1;
            if (pay_last) begin
              TX_BUFF_END <= 1'b1;
              id_reg      <= id_reg + 16'd1;
              state_reg   <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_gemac_udp_tx.sv
module tb_aq_gemac_udp_tx;

  localparam logic [31:0] MY_IP = 32'hC0A8010A;
  localparam logic [31:0] PEER  = 32'hC0A80101;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        APP_START = 1'b0;
  logic [15:0] APP_LENGTH = '0, APP_SRC_PORT = '0, APP_DST_PORT = '0;
  logic        APP_BUSY, APP_LEN_ERR, APP_READY;
  logic [31:0] APP_DATA = '0;
  logic        APP_VALID = 1'b0;
  logic        TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END;
  logic [31:0] TX_BUFF_DATA;
  logic        TX_BUFF_READY = 1'b1;
  logic        TX_BUFF_FULL = 1'b0;
  logic [9:0]  TX_BUFF_SPACE = 10'd1023;

  int checks = 0;
  int fails  = 0;
  int len_err_cnt = 0, busy_cnt = 0, end_cnt = 0, strobe_err = 0;
  logic [31:0] cap_data[$];
  logic        cap_start[$], cap_end[$];
  logic [31:0] pay_q[$], exp_q[$];

  always #5 CLK = ~CLK;

  aq_gemac_udp_tx dut (
    .CLK(CLK), .RST_N(RST_N),
    .MY_IP_ADDRESS(MY_IP), .PEER_IP_ADDRESS(PEER),
    .APP_START(APP_START), .APP_LENGTH(APP_LENGTH),
    .APP_SRC_PORT(APP_SRC_PORT), .APP_DST_PORT(APP_DST_PORT),
    .APP_BUSY(APP_BUSY), .APP_LEN_ERR(APP_LEN_ERR),
    .APP_DATA(APP_DATA), .APP_VALID(APP_VALID), .APP_READY(APP_READY),
    .TX_BUFF_WE(TX_BUFF_WE), .TX_BUFF_START(TX_BUFF_START),
    .TX_BUFF_END(TX_BUFF_END), .TX_BUFF_DATA(TX_BUFF_DATA),
    .TX_BUFF_READY(TX_BUFF_READY), .TX_BUFF_FULL(TX_BUFF_FULL),
    .TX_BUFF_SPACE(TX_BUFF_SPACE)
  );

  // Output monitor: records every written word, away from the active edge.
  always @(negedge CLK) begin
    if (TX_BUFF_WE) begin
      cap_data.push_back(TX_BUFF_DATA);
      cap_start.push_back(TX_BUFF_START);
      cap_end.push_back(TX_BUFF_END);
      if (TX_BUFF_END) end_cnt++;
      $display("word %0d: data=%08h start=%0b end=%0b", cap_data.size() - 1,
               TX_BUFF_DATA, TX_BUFF_START, TX_BUFF_END);
    end
    if ((TX_BUFF_START || TX_BUFF_END) && !TX_BUFF_WE) strobe_err++;
    if (APP_LEN_ERR) len_err_cnt++;
    if (APP_BUSY) busy_cnt++;
  end

  function automatic logic [15:0] csum_model(input logic [15:0] tot, input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + 32'(tot) + 32'(id) + 32'h4000 + 32'h4011 +
        32'(MY_IP[31:16]) + 32'(MY_IP[15:0]) + 32'(PEER[31:16]) + 32'(PEER[15:0]);
    s = (s & 32'hFFFF) + (s >> 16);
    s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic void build_exp(input logic [15:0] len, input logic [15:0] id,
                                    input logic [15:0] sp, input logic [15:0] dp);
    logic [15:0] tot, udp;
    logic [31:0] w;
    tot = len + 16'd28;
    udp = len + 16'd8;
    exp_q.delete();
    exp_q.push_back({8'h45, 8'h00, tot});
    exp_q.push_back({id, 16'h4000});
    exp_q.push_back({8'h40, 8'h11, csum_model(tot, id)});
    exp_q.push_back(MY_IP);
    exp_q.push_back(PEER);
    exp_q.push_back({sp, dp});
    exp_q.push_back({udp, 16'h0000});
    for (int i = 0; i < pay_q.size(); i++) begin
      w = pay_q[i];
      if (i == pay_q.size() - 1) begin
        case (len[1:0])
          2'd1: w = w & 32'hFF000000;
          2'd2: w = w & 32'hFFFF0000;
          2'd3: w = w & 32'hFFFFFF00;
          default: ;
        endcase
      end
      exp_q.push_back(w);
    end
  endfunction

  task automatic tick;
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_caps;
    cap_data.delete();
    cap_start.delete();
    cap_end.delete();
  endtask

  task automatic send_req(input logic [15:0] len, input logic [15:0] sp, input logic [15:0] dp);
    tick;
    APP_START = 1'b1;
    APP_LENGTH = len;
    APP_SRC_PORT = sp;
    APP_DST_PORT = dp;
    tick;
    APP_START = 1'b0;
  endtask

  // Presents pay_q word by word; gappy mode inserts VALID gaps and FULL pulses.
  task automatic feed(input bit gappy);
    int budget;
    for (int i = 0; i < pay_q.size(); i++) begin
      budget = 0;
      APP_DATA = pay_q[i];
      if (gappy && (i % 2 == 1)) begin
        APP_VALID = 1'b0;
        tick;
        tick;
      end
      APP_VALID = 1'b1;
      forever begin
        if (gappy) TX_BUFF_FULL = (budget % 3 == 0);
        #1;
        if (APP_READY) begin
          tick;
          break;
        end
        tick;
        budget++;
        if (budget > 300) break;
      end
      checks++;
      if (budget > 300) begin
        fails++;
        $display("FAIL feed_handshake word %0d: got no APP_READY, required handshake within 300 cycles", i);
      end
    end
    APP_VALID = 1'b0;
    TX_BUFF_FULL = 1'b0;
  endtask

  task automatic wait_end(input string name, input int target);
    int n;
    n = 0;
    while (end_cnt < target && n < 500) begin
      tick;
      n++;
    end
    checks++;
    if (end_cnt < target) begin
      fails++;
      $display("FAIL %s: got end_cnt=%0d, required %0d within 500 cycles", name, end_cnt, target);
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    tick;
    tick;
    checks++;
    if ({TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END, APP_BUSY, APP_LEN_ERR, APP_READY} !== 6'b0 ||
        TX_BUFF_DATA !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got we/st/end/busy/err/rdy=%b%b%b%b%b%b data=%08h, required all 0",
               TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END, APP_BUSY, APP_LEN_ERR, APP_READY, TX_BUFF_DATA);
    end
    RST_N = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int e0;
    clear_caps();
    pay_q = '{32'h01020304, 32'h05060708};
    e0 = end_cnt;
    send_req(16'd8, 16'h1234, 16'h5678);
    feed(1'b0);
    checks++;
    if (TX_BUFF_END !== 1'b1 || APP_BUSY !== 1'b1) begin
      fails++;
      $display("FAIL basic_end_cycle: got end=%b busy=%b, required end=1 busy=1", TX_BUFF_END, APP_BUSY);
    end
    tick;
    checks++;
    if (APP_BUSY !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_drop: got busy=%b, required 0", APP_BUSY);
    end
    wait_end("basic_end", e0 + 1);
    build_exp(16'd8, 16'd0, 16'h1234, 16'h5678);
    checks++;
    if (cap_data.size() != 9) begin
      fails++;
      $display("FAIL basic_count: got %0d words, required 9", cap_data.size());
    end else begin
      checks++;
      if (cap_data[0] !== 32'h45000024) begin
        fails++; $display("FAIL basic_w0: got %08h, required 45000024", cap_data[0]);
      end
      checks++;
      if (cap_data[1] !== 32'h00004000) begin
        fails++; $display("FAIL basic_w1: got %08h, required 00004000", cap_data[1]);
      end
      checks++;
      if (cap_data[2] !== 32'h4011B76D) begin
        fails++; $display("FAIL basic_w2_csum: got %08h, required 4011b76d", cap_data[2]);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (cap_data[i] !== exp_q[i] || cap_start[i] !== (i == 0) || cap_end[i] !== (i == 8)) begin
          fails++;
          $display("FAIL basic_word%0d: got %08h st=%b end=%b, required %08h st=%0b end=%0b",
                   i, cap_data[i], cap_start[i], cap_end[i], exp_q[i], i == 0, i == 8);
        end
      end
    end
  endtask

  task automatic test_len5;
    int e0;
    clear_caps();
    pay_q = '{32'h11223344, 32'hAABBCCDD};
    e0 = end_cnt;
    send_req(16'd5, 16'h1234, 16'h5678);
    feed(1'b0);
    wait_end("len5_end", e0 + 1);
    build_exp(16'd5, 16'd1, 16'h1234, 16'h5678);
    checks++;
    if (cap_data.size() != 9) begin
      fails++;
      $display("FAIL len5_count: got %0d words, required 9", cap_data.size());
    end else begin
      checks++;
      if (cap_data[8] !== 32'hAA000000) begin
        fails++; $display("FAIL len5_mask: got %08h, required aa000000", cap_data[8]);
      end
      checks++;
      if (cap_data[0][15:0] !== 16'h0021 || cap_data[6][31:16] !== 16'h000D) begin
        fails++;
        $display("FAIL len5_lengths: got totlen=%04h udplen=%04h, required 0021 000d",
                 cap_data[0][15:0], cap_data[6][31:16]);
      end
      checks++;
      if (cap_data[1] !== 32'h00014000) begin
        fails++; $display("FAIL len5_id: got %08h, required 00014000", cap_data[1]);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (cap_data[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL len5_word%0d: got %08h, required %08h", i, cap_data[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_len0;
    int e0;
    clear_caps();
    pay_q.delete();
    e0 = end_cnt;
    send_req(16'd0, 16'h0001, 16'h0002);
    wait_end("len0_end", e0 + 1);
    tick;
    tick;
    build_exp(16'd0, 16'd2, 16'h0001, 16'h0002);
    checks++;
    if (cap_data.size() != 7) begin
      fails++;
      $display("FAIL len0_count: got %0d words, required 7", cap_data.size());
    end else begin
      checks++;
      if (cap_data[6] !== 32'h00080000 || cap_end[6] !== 1'b1 || cap_start[0] !== 1'b1) begin
        fails++;
        $display("FAIL len0_w6: got %08h end=%b start0=%b, required 00080000 end=1 start0=1",
                 cap_data[6], cap_end[6], cap_start[0]);
      end
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (cap_data[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL len0_word%0d: got %08h, required %08h", i, cap_data[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_len_err;
    int err0, busy0;
    clear_caps();
    err0 = len_err_cnt;
    busy0 = busy_cnt;
    send_req(16'd1473, 16'h1234, 16'h5678);
    repeat (8) tick;
    checks++;
    if (len_err_cnt - err0 != 1) begin
      fails++;
      $display("FAIL len_err_pulse: got %0d pulse cycles, required 1", len_err_cnt - err0);
    end
    checks++;
    if (cap_data.size() != 0 || busy_cnt != busy0) begin
      fails++;
      $display("FAIL len_err_quiet: got %0d words, %0d busy cycles, required 0 and 0",
               cap_data.size(), busy_cnt - busy0);
    end
  endtask

  task automatic test_space_wait;
    int e0;
    clear_caps();
    pay_q = '{32'hDEADBEEF, 32'hCAFEF00D};
    e0 = end_cnt;
    TX_BUFF_SPACE = 10'd8;
    send_req(16'd8, 16'h1234, 16'h5678);
    repeat (10) tick;
    checks++;
    if (cap_data.size() != 0) begin
      fails++;
      $display("FAIL space_hold: got %0d words while SPACE=8, required 0", cap_data.size());
    end
    TX_BUFF_SPACE = 10'd9;
    tick;
    checks++;
    if (cap_data.size() != 1 || TX_BUFF_DATA !== 32'h45000024 || TX_BUFF_START !== 1'b1) begin
      fails++;
      $display("FAIL space_release: got %0d words data=%08h start=%b, required 1 word 45000024 start=1",
               cap_data.size(), TX_BUFF_DATA, TX_BUFF_START);
    end
    feed(1'b0);
    wait_end("space_end", e0 + 1);
    TX_BUFF_SPACE = 10'd1023;
    build_exp(16'd8, 16'd3, 16'h1234, 16'h5678);
    checks++;
    if (cap_data.size() != 9) begin
      fails++;
      $display("FAIL space_count: got %0d words, required 9", cap_data.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (cap_data[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL space_word%0d: got %08h, required %08h", i, cap_data[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_pressure;
    int e0;
    clear_caps();
    pay_q = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243};
    e0 = end_cnt;
    send_req(16'd16, 16'hABCD, 16'h0050);
    feed(1'b1);
    wait_end("bp_end", e0 + 1);
    tick;
    build_exp(16'd16, 16'd4, 16'hABCD, 16'h0050);
    checks++;
    if (cap_data.size() != 11) begin
      fails++;
      $display("FAIL bp_count: got %0d words, required 11", cap_data.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (cap_data[i] !== exp_q[i] || cap_end[i] !== (i == 10)) begin
          fails++;
          $display("FAIL bp_word%0d: got %08h end=%b, required %08h end=%0b",
                   i, cap_data[i], cap_end[i], exp_q[i], i == 10);
        end
      end
    end
    checks++;
    if (strobe_err != 0) begin
      fails++;
      $display("FAIL strobe_without_we: got %0d cycles, required 0", strobe_err);
    end
  endtask

  task automatic test_reset_mid_pay;
    int e0, n;
    clear_caps();
    pay_q = '{32'h01020304, 32'h05060708};
    send_req(16'd8, 16'h1234, 16'h5678);
    APP_DATA = pay_q[0];
    APP_VALID = 1'b1;
    n = 0;
    while (!APP_READY && n < 100) begin
      tick;
      n++;
    end
    tick;
    APP_VALID = 1'b0;
    checks++;
    if (TX_BUFF_WE !== 1'b1 || APP_BUSY !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_state: got we=%b busy=%b, required 1 1 in PAY", TX_BUFF_WE, APP_BUSY);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END, APP_BUSY, APP_LEN_ERR, APP_READY} !== 6'b0 ||
        TX_BUFF_DATA !== 32'h0) begin
      fails++;
      $display("FAIL rst_async_clear: got we/st/end/busy/err/rdy=%b%b%b%b%b%b data=%08h, required all 0",
               TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END, APP_BUSY, APP_LEN_ERR, APP_READY, TX_BUFF_DATA);
    end
    tick;
    tick;
    RST_N = 1'b1;
    tick;
    clear_caps();
    pay_q.delete();
    e0 = end_cnt;
    send_req(16'd0, 16'h1234, 16'h5678);
    wait_end("rst_next_end", e0 + 1);
    checks++;
    if (cap_data.size() != 7 || cap_data[1] !== 32'h00004000) begin
      fails++;
      $display("FAIL rst_next_id: got %0d words w1=%08h, required 7 words w1=00004000",
               cap_data.size(), cap_data.size() > 1 ? cap_data[1] : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len5();
    test_len0();
    test_len_err();
    test_space_wait();
    test_back_pressure();
    test_reset_mid_pay();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
